// File: rtl/cword_injector_if.sv
// Command channel of the control-word injector: valid/ready push of
// {control word, hold count, last flag} into the injector's FIFO.
interface cword_injector_if #(
    parameter int CW_WIDTH = 32,
    parameter int HOLD_W   = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CW_WIDTH-1:0] cmd_cword;
    logic [HOLD_W-1:0]   cmd_hold;
    logic                cmd_last;

    modport master (output cmd_valid, cmd_cword, cmd_hold, cmd_last, input cmd_ready);
    modport slave  (input cmd_valid, cmd_cword, cmd_hold, cmd_last, output cmd_ready);
endinterface

// File: rtl/cword_injector.sv
// External control-word bus master: queues commands, takes the bus from on-chip
// control, replays each word for its hold count. Optional step trace via CWI_TRACE_EN.
module cword_injector #(
    parameter int CW_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    cword_injector_if.slave     cmd,
    output logic                ctrlen,
    output logic [CW_WIDTH-1:0] cword_out,
    output logic                cword_oe,
    output logic                step,
    input  logic                brk,
    input  logic                resume,
    input  logic                abort,
    output logic                busy,
    output logic                halted,
    output logic                done,
    output logic [15:0]         trace_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HANDOVER, S_DRIVE, S_STARVE, S_HALTED, S_RELEASE
    } state_t;

    state_t              r_state, w_state_n;
    logic [CW_WIDTH-1:0] r_mem_cw   [FIFO_DEPTH];
    logic [HOLD_W-1:0]   r_mem_hold [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [PTR_W:0]      r_count, w_count_n;
    logic                r_full;
    logic                w_empty, w_push, w_pop, w_flush;
    logic [HOLD_W-1:0]   r_cnt, w_cnt_n, w_head_hold;
    logic                r_last, w_last_n;
    logic [CW_WIDTH-1:0] r_cword, w_cword_n;
    logic                r_ctrlen, r_oe, r_step, r_busy, r_halted, r_done;

    assign w_empty     = (r_count == '0);
    assign w_push      = cmd.cmd_valid && !r_full && !w_flush;
    assign w_head_hold = (r_mem_hold[r_rptr] == '0) ? HOLD_W'(1) : r_mem_hold[r_rptr];
    assign w_count_n   = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_last_n  = r_last;
        w_cword_n = r_cword;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (abort)         w_flush   = 1'b1;
                else if (!w_empty) w_state_n = S_HANDOVER;
            end
            S_RELEASE: begin
                w_flush   = abort;
                w_state_n = S_IDLE;
            end
            default: begin
                if (abort) begin
                    w_flush   = 1'b1;
                    w_state_n = S_RELEASE;
                end else begin
                    case (r_state)
                        S_HANDOVER: begin
                            w_pop     = !w_empty;
                            w_state_n = w_empty ? S_RELEASE : S_DRIVE;
                        end
                        // A back-to-back pop still honours brk; the new word is held frozen.
                        S_DRIVE: begin
                            if (r_cnt <= HOLD_W'(1)) begin
                                if (r_last)       w_state_n = S_RELEASE;
                                else if (w_empty) w_state_n = S_STARVE;
                                else begin
                                    w_pop     = 1'b1;
                                    w_state_n = brk ? S_HALTED : S_DRIVE;
                                end
                            end else begin
                                w_cnt_n   = r_cnt - 1'b1;
                                w_state_n = brk ? S_HALTED : S_DRIVE;
                            end
                        end
                        S_STARVE: begin
                            if (!w_empty) begin
                                w_pop     = 1'b1;
                                w_state_n = S_DRIVE;
                            end
                        end
                        S_HALTED: if (resume) w_state_n = S_DRIVE;
                        default:  w_state_n = S_IDLE;
                    endcase
                end
            end
        endcase
        if (w_pop) begin
            w_cword_n = r_mem_cw[r_rptr];
            w_cnt_n   = w_head_hold;
            w_last_n  = r_mem_last[r_rptr];
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_cword  <= '0;
            r_ctrlen <= 1'b1;
            r_oe     <= 1'b0;
            r_step   <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_last   <= w_last_n;
            r_cword  <= w_cword_n;
            r_ctrlen <= (w_state_n == S_IDLE);
            r_oe     <= (w_state_n inside {S_DRIVE, S_STARVE, S_HALTED});
            r_step   <= (w_state_n == S_DRIVE);
            r_busy   <= (w_state_n != S_IDLE);
            r_halted <= (w_state_n == S_HALTED);
            r_done   <= (w_state_n == S_IDLE) && (r_state != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_n;
            r_full  <= (w_count_n == (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cw[r_wptr]   <= cmd.cmd_cword;
            r_mem_hold[r_wptr] <= cmd.cmd_hold;
            r_mem_last[r_wptr] <= cmd.cmd_last;
        end
    end

`ifdef CWI_TRACE_EN
    logic [15:0] r_trace;
    always_ff @(posedge clk) begin
        if (rst)                        r_trace <= '0;
        else if (r_step && r_trace != '1) r_trace <= r_trace + 1'b1;
    end
    assign trace_count = r_trace;
`else
    assign trace_count = '0;
`endif

    assign cmd.cmd_ready = !r_full;
    assign ctrlen        = r_ctrlen;
    assign cword_out     = r_cword;
    assign cword_oe      = r_oe;
    assign step          = r_step;
    assign busy          = r_busy;
    assign halted        = r_halted;
    assign done          = r_done;
endmodule
